// File: rtl/clc_flag_multi.sv
// Music-select change detector: settles music_reg changes, then pulses per-channel counter clears.
// Optional start-up clear of every channel when CLC_INIT_PULSE_EN is defined.
module clc_flag_multi #(
    parameter int SEL_W      = 2,
    parameter int NUM_CH     = 2,
    parameter int SETTLE_CYC = 4,
    parameter int PULSE_LEN  = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [SEL_W-1:0]  i_music_reg,
    input  logic [NUM_CH-1:0] i_clr_mask,
    output logic [NUM_CH-1:0] o_cnt_clc,
    output logic [SEL_W-1:0]  o_sel_stable,
    output logic              o_busy,
    output logic [7:0]        o_chg_cnt
);

    localparam int MW = $clog2(SETTLE_CYC + 1);
    localparam int PW = $clog2(PULSE_LEN + 1);
    localparam logic [MW-1:0] MATCH_ONE   = MW'(1);
    localparam logic [MW-1:0] SETTLE_LAST = MW'(SETTLE_CYC - 1);
    localparam logic [PW-1:0] PULSE_ONE   = PW'(1);
    localparam logic [PW-1:0] PULSE_INIT  = PW'(PULSE_LEN);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        PULSE  = 2'd2
    } state_t;

    state_t            r_state;
    logic [SEL_W-1:0]  r_cand;
    logic [MW-1:0]     r_match_cnt;
    logic [PW-1:0]     r_pulse_cnt;
    logic [NUM_CH-1:0] r_cnt_clc;
    logic [SEL_W-1:0]  r_sel_stable;
    logic              r_busy;
    logic [7:0]        r_chg_cnt;

    state_t            w_state_nxt;
    logic [SEL_W-1:0]  w_cand_nxt;
    logic [MW-1:0]     w_match_nxt;
    logic [PW-1:0]     w_pulse_nxt;
    logic [NUM_CH-1:0] w_clc_nxt;
    logic [SEL_W-1:0]  w_sel_nxt;
    logic [7:0]        w_chg_nxt;
    logic              w_accept;
    logic [SEL_W-1:0]  w_accept_sel;
    logic              w_init_pend;

`ifdef CLC_INIT_PULSE_EN
    // Set by reset, consumed by the first IDLE edge to launch the power-on clear.
    logic r_init_pend;

    always_ff @(posedge i_clk) begin
        if (i_rst) r_init_pend <= 1'b1;
        else       r_init_pend <= 1'b0;
    end

    assign w_init_pend = r_init_pend;
`else
    assign w_init_pend = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_cand       <= '0;
            r_match_cnt  <= '0;
            r_pulse_cnt  <= '0;
            r_cnt_clc    <= '0;
            r_sel_stable <= '0;
            r_busy       <= 1'b0;
            r_chg_cnt    <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_cand       <= w_cand_nxt;
            r_match_cnt  <= w_match_nxt;
            r_pulse_cnt  <= w_pulse_nxt;
            r_cnt_clc    <= w_clc_nxt;
            r_sel_stable <= w_sel_nxt;
            r_busy       <= (w_state_nxt != IDLE);
            r_chg_cnt    <= w_chg_nxt;
        end
    end

    // Acceptance is collected into one override at the end so IDLE (SETTLE_CYC==1) and SETTLE share it.
    always_comb begin
        w_state_nxt  = r_state;
        w_cand_nxt   = r_cand;
        w_match_nxt  = r_match_cnt;
        w_pulse_nxt  = r_pulse_cnt;
        w_clc_nxt    = r_cnt_clc;
        w_sel_nxt    = r_sel_stable;
        w_chg_nxt    = r_chg_cnt;
        w_accept     = 1'b0;
        w_accept_sel = r_cand;

        case (r_state)
            IDLE: begin
                if (w_init_pend) begin
                    w_sel_nxt   = i_music_reg;
                    w_clc_nxt   = '1;
                    w_pulse_nxt = PULSE_INIT;
                    w_state_nxt = PULSE;
                end else if (i_music_reg != r_sel_stable) begin
                    w_cand_nxt  = i_music_reg;
                    w_match_nxt = MATCH_ONE;
                    if (SETTLE_CYC == 1) begin
                        w_accept     = 1'b1;
                        w_accept_sel = i_music_reg;
                    end else begin
                        w_state_nxt = SETTLE;
                    end
                end
            end
            SETTLE: begin
                if (i_music_reg == r_sel_stable) begin
                    w_state_nxt = IDLE;
                    w_match_nxt = '0;
                end else if (i_music_reg != r_cand) begin
                    w_cand_nxt  = i_music_reg;
                    w_match_nxt = MATCH_ONE;
                end else if (r_match_cnt == SETTLE_LAST) begin
                    w_accept     = 1'b1;
                    w_accept_sel = r_cand;
                end else begin
                    w_match_nxt = r_match_cnt + MATCH_ONE;
                end
            end
            PULSE: begin
                if (r_pulse_cnt <= PULSE_ONE) begin
                    w_clc_nxt   = '0;
                    w_pulse_nxt = '0;
                    w_state_nxt = IDLE;
                end else begin
                    w_pulse_nxt = r_pulse_cnt - PULSE_ONE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        if (w_accept) begin
            w_sel_nxt   = w_accept_sel;
            w_clc_nxt   = i_clr_mask;
            w_chg_nxt   = r_chg_cnt + 8'd1;
            w_pulse_nxt = PULSE_INIT;
            w_match_nxt = '0;
            w_state_nxt = PULSE;
        end
    end

    assign o_cnt_clc    = r_cnt_clc;
    assign o_sel_stable = r_sel_stable;
    assign o_busy       = r_busy;
    assign o_chg_cnt    = r_chg_cnt;

endmodule

// File: tb/tb_clc_flag_multi.sv
// Testbench for clc_flag_multi: directed scenarios plus randomized run against a behavioural model.
module tb_clc_flag_multi;

    localparam int SEL_W      = 2;
    localparam int NUM_CH     = 2;
    localparam int SETTLE_CYC = 3;
    localparam int PULSE_LEN  = 2;

    logic              clk   = 1'b0;
    logic              rst   = 1'b1;
    logic [SEL_W-1:0]  music = '0;
    logic [NUM_CH-1:0] mask  = 2'b11;
    logic [NUM_CH-1:0] cntClc;
    logic [SEL_W-1:0]  selStable;
    logic              busy;
    logic [7:0]        chgCnt;

    int nTests = 0;
    int nFail  = 0;

    clc_flag_multi #(
        .SEL_W(SEL_W), .NUM_CH(NUM_CH), .SETTLE_CYC(SETTLE_CYC), .PULSE_LEN(PULSE_LEN)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_music_reg(music), .i_clr_mask(mask),
        .o_cnt_clc(cntClc), .o_sel_stable(selStable), .o_busy(busy), .o_chg_cnt(chgCnt)
    );

    always #5 clk = ~clk;

    // Behavioural model: run length of a differing selection, and remaining pulse cycles.
    logic [SEL_W-1:0]  mStable;
    logic [SEL_W-1:0]  mRunVal;
    logic [NUM_CH-1:0] mMaskHeld;
    logic [7:0]        mChg;
    int                mRun;
    int                mPulseLeft;

    task automatic model_step();
        if (rst) begin
            mStable = '0; mRunVal = '0; mMaskHeld = '0; mChg = '0; mRun = 0; mPulseLeft = 0;
        end else if (mPulseLeft > 0) begin
            mPulseLeft--;
        end else if (music == mStable) begin
            mRun = 0;
        end else begin
            if (mRun > 0 && music == mRunVal) mRun++;
            else begin mRunVal = music; mRun = 1; end
            if (mRun == SETTLE_CYC) begin
                mStable = music; mMaskHeld = mask; mChg = mChg + 8'd1;
                mPulseLeft = PULSE_LEN; mRun = 0;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [12:0] obs;
        rst = 1'b1; music = '0; mask = 2'b11;
        tick(); tick();
        obs = {cntClc, selStable, busy, chgCnt};
        nTests++;
        if (obs !== 13'h0) begin nFail++; $display("[TB] FAIL reset_state: got %h expected %h", obs, 13'h0); end
        rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            obs = {cntClc, selStable, busy, chgCnt};
            nTests++;
            if (obs !== 13'h0) begin nFail++; $display("[TB] FAIL idle_hold cyc%0d: got %h expected %h", i, obs, 13'h0); end
        end
    endtask

    task automatic test_change();
        logic [12:0] exp [5];
        logic [12:0] obs;
        exp[0] = {2'b00, 2'd0, 1'b1, 8'd0};
        exp[1] = {2'b00, 2'd0, 1'b1, 8'd0};
        exp[2] = {2'b11, 2'd2, 1'b1, 8'd1};
        exp[3] = {2'b11, 2'd2, 1'b1, 8'd1};
        exp[4] = {2'b00, 2'd2, 1'b0, 8'd1};
        music = 2'd2;
        for (int i = 0; i < 5; i++) begin
            tick();
            obs = {cntClc, selStable, busy, chgCnt};
            nTests++;
            if (obs !== exp[i]) begin nFail++; $display("[TB] FAIL change edge k+%0d: got %h expected %h", i, obs, exp[i]); end
        end
    endtask

    task automatic test_glitch();
        logic [12:0] obs;
        music = 2'd3;
        tick();
        obs = {cntClc, selStable, busy, chgCnt};
        nTests++;
        if (obs !== {2'b00, 2'd2, 1'b1, 8'd1}) begin nFail++; $display("[TB] FAIL glitch_busy: got %h expected %h", obs, {2'b00, 2'd2, 1'b1, 8'd1}); end
        music = 2'd2;
        for (int i = 0; i < 4; i++) begin
            tick();
            obs = {cntClc, selStable, busy, chgCnt};
            nTests++;
            if (obs !== {2'b00, 2'd2, 1'b0, 8'd1}) begin nFail++; $display("[TB] FAIL glitch_reject cyc%0d: got %h expected %h", i, obs, {2'b00, 2'd2, 1'b0, 8'd1}); end
        end
    endtask

    task automatic test_restart();
        logic [12:0] exp [5];
        logic [12:0] obs;
        music = 2'd1;
        tick(); tick();
        obs = {cntClc, selStable, busy, chgCnt};
        nTests++;
        if (obs !== {2'b00, 2'd2, 1'b1, 8'd1}) begin nFail++; $display("[TB] FAIL restart_pre: got %h expected %h", obs, {2'b00, 2'd2, 1'b1, 8'd1}); end
        exp[0] = {2'b00, 2'd2, 1'b1, 8'd1};
        exp[1] = {2'b00, 2'd2, 1'b1, 8'd1};
        exp[2] = {2'b11, 2'd3, 1'b1, 8'd2};
        exp[3] = {2'b11, 2'd3, 1'b1, 8'd2};
        exp[4] = {2'b00, 2'd3, 1'b0, 8'd2};
        music = 2'd3;
        for (int i = 0; i < 5; i++) begin
            tick();
            obs = {cntClc, selStable, busy, chgCnt};
            nTests++;
            if (obs !== exp[i]) begin nFail++; $display("[TB] FAIL restart edge %0d: got %h expected %h", i, obs, exp[i]); end
        end
    endtask

    task automatic test_mask();
        logic [12:0] exp [5];
        logic [12:0] obs;
        exp[0] = {2'b00, 2'd3, 1'b1, 8'd2};
        exp[1] = {2'b00, 2'd3, 1'b1, 8'd2};
        exp[2] = {2'b01, 2'd0, 1'b1, 8'd3};
        exp[3] = {2'b01, 2'd0, 1'b1, 8'd3};
        exp[4] = {2'b00, 2'd0, 1'b0, 8'd3};
        mask = 2'b01; music = 2'd0;
        for (int i = 0; i < 5; i++) begin
            tick();
            obs = {cntClc, selStable, busy, chgCnt};
            nTests++;
            if (obs !== exp[i]) begin nFail++; $display("[TB] FAIL mask edge %0d: got %h expected %h", i, obs, exp[i]); end
        end
        mask = 2'b11;
    endtask

    task automatic test_reset_mid_pulse();
        logic [12:0] obs;
        music = 2'd2;
        tick(); tick(); tick();
        obs = {cntClc, selStable, busy, chgCnt};
        nTests++;
        if (obs !== {2'b11, 2'd2, 1'b1, 8'd4}) begin nFail++; $display("[TB] FAIL pulse_before_rst: got %h expected %h", obs, {2'b11, 2'd2, 1'b1, 8'd4}); end
        rst = 1'b1; music = 2'd0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            obs = {cntClc, selStable, busy, chgCnt};
            nTests++;
            if (obs !== 13'h0) begin nFail++; $display("[TB] FAIL rst_mid_pulse cyc%0d: got %h expected %h", i, obs, 13'h0); end
            tick();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(3, 0) == 0) music = SEL_W'($urandom_range(3, 0));
            mask = NUM_CH'($urandom_range(3, 0));
            rst  = ($urandom_range(299, 0) == 0);
            tick();
            nTests++;
            if ({cntClc, selStable, busy, chgCnt} !== {(mPulseLeft > 0) ? mMaskHeld : 2'b00, mStable, (mPulseLeft > 0) || (mRun > 0), mChg}) begin
                nFail++;
                $display("[TB] FAIL random cyc%0d: got clc=%b sel=%0d busy=%b chg=%0d expected clc=%b sel=%0d busy=%b chg=%0d",
                         i, cntClc, selStable, busy, chgCnt, (mPulseLeft > 0) ? mMaskHeld : 2'b00, mStable,
                         (mPulseLeft > 0) || (mRun > 0), mChg);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_change();
        test_glitch();
        test_restart();
        test_mask();
        test_reset_mid_pulse();
        test_random();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
